// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
// Shares one downstream Wishbone port between two requesters (m0: fetch,
// m1: data). A burst stays atomic: the winner holds the grant until every
// ack/err of its burst has returned. An aborted burst is drained: the
// remaining acks are absorbed without being forwarded.
//
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   mX_wb_{cyc,stb,we,adr,o_dat,sel,8_burst,4_burst}  requester inputs
//   mX_wb_{i_dat,ack,err}        requester responses (ack/err to grantee only)
//   s_wb_{cyc,stb,we,adr,o_dat,sel,8_burst,4_burst}   downstream request
//   s_wb_{i_dat,ack,err}         downstream response
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration when
// both masters request together; otherwise m0 has fixed priority.

`ifndef RW
`define RW 16
`endif
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_master_arbiter #(
  parameter int MAX_BURST_LOG = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  m0_wb_cyc,
  input  logic                  m0_wb_stb,
  input  logic                  m0_wb_we,
  input  logic [`WB_ADDR_W-1:0] m0_wb_adr,
  input  logic [`RW-1:0]        m0_wb_o_dat,
  input  logic [1:0]            m0_wb_sel,
  input  logic                  m0_wb_8_burst,
  input  logic                  m0_wb_4_burst,
  output logic [`RW-1:0]        m0_wb_i_dat,
  output logic                  m0_wb_ack,
  output logic                  m0_wb_err,
  input  logic                  m1_wb_cyc,
  input  logic                  m1_wb_stb,
  input  logic                  m1_wb_we,
  input  logic [`WB_ADDR_W-1:0] m1_wb_adr,
  input  logic [`RW-1:0]        m1_wb_o_dat,
  input  logic [1:0]            m1_wb_sel,
  input  logic                  m1_wb_8_burst,
  input  logic                  m1_wb_4_burst,
  output logic [`RW-1:0]        m1_wb_i_dat,
  output logic                  m1_wb_ack,
  output logic                  m1_wb_err,
  output logic                  s_wb_cyc,
  output logic                  s_wb_stb,
  output logic                  s_wb_we,
  output logic [`WB_ADDR_W-1:0] s_wb_adr,
  output logic [`RW-1:0]        s_wb_o_dat,
  output logic [1:0]            s_wb_sel,
  output logic                  s_wb_8_burst,
  output logic                  s_wb_4_burst,
  input  logic [`RW-1:0]        s_wb_i_dat,
  input  logic                  s_wb_ack,
  input  logic                  s_wb_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_e;
  typedef logic [MAX_BURST_LOG-1:0] rem_t;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d, last_q, last_d;
  rem_t   rem_q, rem_d, rem_dec;

  logic req0, req1, win, live;
  logic g_cyc, g_stb, g_we, g_8, g_4;
  logic [`WB_ADDR_W-1:0] g_adr;
  logic [`RW-1:0]        g_dat;
  logic [1:0]            g_sel;

  // Writes are always single-beat; reads take their length from the hints.
  function automatic rem_t burst_len(input logic we, input logic b8, input logic b4);
    if (we)      return rem_t'(1);
    else if (b8) return rem_t'(8);
    else if (b4) return rem_t'(4);
    else         return rem_t'(1);
  endfunction

  assign req0 = m0_wb_cyc & m0_wb_stb;
  assign req1 = m1_wb_cyc & m1_wb_stb;

`ifdef ARB_ROUND_ROBIN_EN
  assign win = (req0 & req1) ? ~last_q : req1;
`else
  assign win = ~req0;
`endif

  // Request fields of the currently granted master.
  assign g_cyc = gnt_q ? m1_wb_cyc     : m0_wb_cyc;
  assign g_stb = gnt_q ? m1_wb_stb     : m0_wb_stb;
  assign g_we  = gnt_q ? m1_wb_we      : m0_wb_we;
  assign g_8   = gnt_q ? m1_wb_8_burst : m0_wb_8_burst;
  assign g_4   = gnt_q ? m1_wb_4_burst : m0_wb_4_burst;
  assign g_adr = gnt_q ? m1_wb_adr     : m0_wb_adr;
  assign g_dat = gnt_q ? m1_wb_o_dat   : m0_wb_o_dat;
  assign g_sel = gnt_q ? m1_wb_sel     : m0_wb_sel;

  // An ack/err only counts while beats are outstanding; ack+err together
  // consume a single beat, and stray responses at rem=0 cannot underflow.
  assign live    = (s_wb_ack | s_wb_err) & (rem_q != '0);
  assign rem_dec = rem_q - rem_t'(live);

  assign m0_wb_i_dat = s_wb_i_dat;
  assign m1_wb_i_dat = s_wb_i_dat;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    rem_d        = rem_q;
    s_wb_cyc     = 1'b0;
    s_wb_stb     = 1'b0;
    s_wb_we      = 1'b0;
    s_wb_adr     = '0;
    s_wb_o_dat   = '0;
    s_wb_sel     = '0;
    s_wb_8_burst = 1'b0;
    s_wb_4_burst = 1'b0;
    m0_wb_ack    = 1'b0;
    m0_wb_err    = 1'b0;
    m1_wb_ack    = 1'b0;
    m1_wb_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win;
          last_d  = win;
          rem_d   = win ? burst_len(m1_wb_we, m1_wb_8_burst, m1_wb_4_burst)
                        : burst_len(m0_wb_we, m0_wb_8_burst, m0_wb_4_burst);
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_wb_cyc     = g_cyc;
        s_wb_stb     = g_stb & (rem_q != '0);
        s_wb_we      = g_we;
        s_wb_adr     = g_adr;
        s_wb_o_dat   = g_dat;
        s_wb_sel     = g_sel;
        s_wb_8_burst = g_8;
        s_wb_4_burst = g_4;
        if (rem_q != '0) begin
          m0_wb_ack = ~gnt_q & s_wb_ack;
          m0_wb_err = ~gnt_q & s_wb_err;
          m1_wb_ack =  gnt_q & s_wb_ack;
          m1_wb_err =  gnt_q & s_wb_err;
        end
        rem_d = rem_dec;
        if (!g_cyc) begin
          // Dropping cyc with beats still owed is an abort.
          state_d = (rem_dec == '0) ? IDLE : DRAIN;
        end else if (rem_q == '0 && g_stb) begin
          // Back-to-back transfer: keep the grant and reload the count.
          rem_d = burst_len(g_we, g_8, g_4);
        end
      end
      DRAIN: begin
        s_wb_cyc = 1'b1;
        rem_d    = rem_dec;
        if (rem_dec == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter. Inputs change 1ns after the rising
// edge; outputs are sampled 1ns later. State/rem are observed hierarchically.
module tb_wb_master_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_cyc, m0_stb, m0_we, m0_b8, m0_b4; logic [23:0] m0_adr; logic [15:0] m0_od; logic [1:0] m0_sel;
  logic m1_cyc, m1_stb, m1_we, m1_b8, m1_b4; logic [23:0] m1_adr; logic [15:0] m1_od; logic [1:0] m1_sel;
  logic [15:0] m0_id, m1_id, s_id, s_od;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic s_cyc, s_stb, s_we, s_b8, s_b4, s_ack, s_err;
  logic [23:0] s_adr; logic [1:0] s_sel;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_master_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_wb_cyc(m0_cyc), .m0_wb_stb(m0_stb), .m0_wb_we(m0_we), .m0_wb_adr(m0_adr),
    .m0_wb_o_dat(m0_od), .m0_wb_sel(m0_sel), .m0_wb_8_burst(m0_b8), .m0_wb_4_burst(m0_b4),
    .m0_wb_i_dat(m0_id), .m0_wb_ack(m0_ack), .m0_wb_err(m0_err),
    .m1_wb_cyc(m1_cyc), .m1_wb_stb(m1_stb), .m1_wb_we(m1_we), .m1_wb_adr(m1_adr),
    .m1_wb_o_dat(m1_od), .m1_wb_sel(m1_sel), .m1_wb_8_burst(m1_b8), .m1_wb_4_burst(m1_b4),
    .m1_wb_i_dat(m1_id), .m1_wb_ack(m1_ack), .m1_wb_err(m1_err),
    .s_wb_cyc(s_cyc), .s_wb_stb(s_stb), .s_wb_we(s_we), .s_wb_adr(s_adr),
    .s_wb_o_dat(s_od), .s_wb_sel(s_sel), .s_wb_8_burst(s_b8), .s_wb_4_burst(s_b4),
    .s_wb_i_dat(s_id), .s_wb_ack(s_ack), .s_wb_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask

  logic [31:0] st, rem;
  assign st  = 32'(dut.state_q);
  assign rem = 32'(dut.rem_q);

  initial begin
    {m0_cyc, m0_stb, m0_we, m0_b8, m0_b4, m0_adr, m0_od, m0_sel} = '0;
    {m1_cyc, m1_stb, m1_we, m1_b8, m1_b4, m1_adr, m1_od, m1_sel} = '0;
    {s_ack, s_err, s_id} = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_s_cyc", 32'(s_cyc), 0); chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
    chk("rst_state", st, 0); chk("rst_rem", rem, 0);
    chk("rst_last", 32'(dut.last_q), 1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: single m1 read, ack two cycles after stb
    m1_cyc = 1; m1_stb = 1; m1_adr = 24'h123456; settle();
    chk("t1_idle_cyc", 32'(s_cyc), 0);
    tick();
    chk("t1_cyc", 32'(s_cyc), 1); chk("t1_stb", 32'(s_stb), 1);
    chk("t1_adr", 32'(s_adr), 32'h123456); chk("t1_gnt", 32'(dut.gnt_q), 1);
    chk("t1_rem", rem, 1);
    tick(); chk("t1_noack", 32'(m1_ack), 0);
    tick();
    s_ack = 1; s_id = 16'hBEEF; m1_cyc = 0; m1_stb = 0; settle();
    chk("t1_m1ack", 32'(m1_ack), 1); chk("t1_m0ack", 32'(m0_ack), 0);
    chk("t1_idat", 32'(m1_id), 32'hBEEF);
    tick(); s_ack = 0; s_id = 0; settle();
    chk("t1_idle", st, 0); chk("t1_m1ack_off", 32'(m1_ack), 0);
    chk("t1_scyc_off", 32'(s_cyc), 0);

    // 2: m0 8-beat read while m1 requests throughout
    m0_cyc = 1; m0_stb = 1; m0_b8 = 1; m0_adr = 24'h000100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 24'h000200;
    tick();
    chk("t2_gnt0", 32'(dut.gnt_q), 0); chk("t2_rem8", rem, 8);
    for (int i = 0; i < 8; i++) begin
      s_ack = 1;
      if (i == 7) begin m0_cyc = 0; m0_stb = 0; m0_b8 = 0; end
      settle();
      chk($sformatf("t2_rem%0d", i), rem, 32'(8 - i));
      chk($sformatf("t2_m0ack%0d", i), 32'(m0_ack), 1);
      chk($sformatf("t2_m1ack%0d", i), 32'(m1_ack), 0);
      chk($sformatf("t2_gnt%0d", i), 32'(dut.gnt_q), 0);
      tick();
    end
    s_ack = 0; settle();
    chk("t2_idle", st, 0); chk("t2_rem0", rem, 0); chk("t2_gap_cyc", 32'(s_cyc), 0);
    tick();
    chk("t2_m1_gnt", 32'(dut.gnt_q), 1); chk("t2_m1_cyc", 32'(s_cyc), 1);
    chk("t2_m1_adr", 32'(s_adr), 32'h000200);
    s_ack = 1; m1_cyc = 0; m1_stb = 0; settle();
    chk("t2_m1ack", 32'(m1_ack), 1);
    tick(); s_ack = 0;

    // 3: both request continuously with 1-beat reads
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int k = 0; k < 4; k++) begin
      logic expg;
`ifdef ARB_ROUND_ROBIN_EN
      expg = k[0];
`else
      expg = 1'b0;
`endif
      tick();
      chk($sformatf("t3_gnt%0d", k), 32'(dut.gnt_q), 32'(expg));
      s_ack = 1;
      if (dut.gnt_q) begin m1_cyc = 0; m1_stb = 0; end
      else begin m0_cyc = 0; m0_stb = 0; end
      tick();
      s_ack = 0; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // 4: m0 4-beat read aborted after first (ack+err) response
    m0_cyc = 1; m0_stb = 1; m0_b4 = 1; m0_adr = 24'h0ABCDE;
    tick();
    chk("t4_rem4", rem, 4);
    s_ack = 1; s_err = 1; settle();
    chk("t4_ack", 32'(m0_ack), 1); chk("t4_err", 32'(m0_err), 1);
    tick();
    s_ack = 0; s_err = 0; m0_cyc = 0; m0_stb = 0; m0_b4 = 0; settle();
    chk("t4_rem3", rem, 3); chk("t4_stb_abort", 32'(s_stb), 0);
    tick();
    chk("t4_drain", st, 2); chk("t4_dcyc", 32'(s_cyc), 1);
    chk("t4_dstb", 32'(s_stb), 0); chk("t4_dadr", 32'(s_adr), 0);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; settle();
      chk($sformatf("t4_drem%0d", i), rem, 32'(3 - i));
      chk($sformatf("t4_nofwd%0d", i), 32'({m0_ack, m1_ack}), 0);
      tick();
    end
    s_ack = 0; settle();
    chk("t4_idle", st, 0); chk("t4_remz", rem, 0);

    // 5: m1 8-burst write is a single beat; stray ack and stb-with-cyc-drop at rem=0
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_b8 = 1; m1_od = 16'hA5A5; m1_sel = 2'b11;
    tick();
    chk("t5_rem1", rem, 1); chk("t5_we", 32'(s_we), 1);
    chk("t5_dat", 32'(s_od), 32'hA5A5); chk("t5_sel", 32'(s_sel), 3);
    chk("t5_b8", 32'(s_b8), 1);
    s_ack = 1; settle();
    chk("t5_ack", 32'(m1_ack), 1);
    tick();
    m1_cyc = 0; m1_stb = 1; settle();
    chk("t5_stray_ack", 32'(m1_ack), 0); chk("t5_stb0", 32'(s_stb), 0);
    tick();
    s_ack = 0; m1_stb = 0; m1_we = 0; m1_b8 = 0; settle();
    chk("t5_idle", st, 0); chk("t5_no_uflow", rem, 0); chk("t5_scyc", 32'(s_cyc), 0);

    // 6: back-to-back reload keeps the grant
    m0_cyc = 1; m0_stb = 1;
    tick();
    s_ack = 1; settle();
    chk("t6_ack", 32'(m0_ack), 1);
    tick();
    s_ack = 0; settle();
    chk("t6_rem0", rem, 0); chk("t6_stb_gap", 32'(s_stb), 0); chk("t6_grant", st, 1);
    tick();
    chk("t6_reload", rem, 1); chk("t6_stb", 32'(s_stb), 1); chk("t6_gnt", 32'(dut.gnt_q), 0);
    s_ack = 1; m0_cyc = 0; m0_stb = 0;
    tick(); s_ack = 0;

    // 7: reset mid-burst with rem = 5
    m0_cyc = 1; m0_stb = 1; m0_b8 = 1;
    tick();
    for (int i = 0; i < 3; i++) begin s_ack = 1; tick(); end
    s_ack = 0; settle();
    chk("t7_rem5", rem, 5); chk("t7_cyc", 32'(s_cyc), 1);
    rst_n = 0; settle();
    chk("t7_rst_cyc", 32'(s_cyc), 0); chk("t7_rst_stb", 32'(s_stb), 0);
    chk("t7_rst_adr", 32'(s_adr), 0); chk("t7_rst_state", st, 0); chk("t7_rst_rem", rem, 0);
    m0_cyc = 0; m0_stb = 0; m0_b8 = 0;
    @(negedge clk); rst_n = 1;
    tick();
    chk("t7_idle", st, 0); chk("t7_rem", rem, 0); chk("t7_scyc", 32'(s_cyc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter that shares one downstream Wishbone port between two requesters, typically instruction fetch (m0) and data access (m1). It sits on the CPU clock side and feeds the master port of the clock-crossing bridge. Bursts are kept atomic: the winning master keeps the grant until every ack or err of its burst has returned. A master that aborts a burst is handled by draining the outstanding acks.

## Interface
Parameters:
- MAX_BURST_LOG, 4: width of the outstanding-ack counter. It must hold 8.
- Port widths come from config.v: `` `RW`` = 16 and `` `WB_ADDR_W`` = 24.

Ports (x = 0, 1):
- i_clk  in  1  clock. All logic is clocked on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- mx_wb_cyc, mx_wb_stb, mx_wb_we  in  1 each  requester control.
- mx_wb_adr  in  `` `WB_ADDR_W``  requester address.
- mx_wb_o_dat  in  `` `RW``  requester write data.
- mx_wb_sel  in  2  requester byte selects.
- mx_wb_8_burst, mx_wb_4_burst  in  1 each  requester burst hints.
- mx_wb_i_dat  out  `` `RW``  read data. Equals s_wb_i_dat and goes to both masters.
- mx_wb_ack, mx_wb_err  out  1 each  ack and err, routed to the granted master only.
- s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  downstream control.
- s_wb_adr  out  `` `WB_ADDR_W``  downstream address.
- s_wb_o_dat  out  `` `RW``  downstream write data.
- s_wb_sel  out  2  downstream byte selects.
- s_wb_8_burst, s_wb_4_burst  out  1 each  downstream burst hints.
- s_wb_i_dat  in  `` `RW``  downstream read data.
- s_wb_ack, s_wb_err  in  1 each  downstream ack and err.

## Operation
The controller has three states: IDLE, GRANT, DRAIN. It also holds:
- gnt: 1 bit, the granted master.
- last: 1 bit, the master granted most recently.
- rem: MAX_BURST_LOG bits, acks still outstanding.

State transitions:
- IDLE, with req0 = m0_wb_cyc & m0_wb_stb and/or req1 asserted:
  - Choose a winner (see Configuration).
  - gnt <= winner, last <= winner.
  - rem <= 1 if the winner's we = 1.
  - Otherwise rem <= 8 if 8_burst, else 4 if 4_burst, else 1.
  - Go to GRANT.
- GRANT: all s_wb_* outputs are driven from master gnt, except s_wb_stb.
  - s_wb_stb = m_gnt_stb & (rem != 0).
  - Each s_wb_ack or s_wb_err decrements rem and is forwarded to master gnt.
  - When rem = 0 and m_gnt_cyc = 0, go to IDLE.
  - When rem = 0 and m_gnt_cyc = 1 with a new stb, reload rem from the current we and burst hints. The grant is kept (back-to-back transfers within one cycle).
  - When m_gnt_cyc = 0 and rem != 0 (abort), go to DRAIN.
- DRAIN:
  - s_wb_cyc = 1 and s_wb_stb = 0.
  - Acks and errs decrement rem but are not forwarded to either master.
  - When rem reaches 0, go to IDLE.
- The non-granted master always sees ack = 0 and err = 0.
- In IDLE and in DRAIN, s_wb_adr, s_wb_o_dat, s_wb_sel, s_wb_we and the burst hints are 0.

Boundary conditions:
- If ack and err arrive in the same cycle, rem is decremented once and both are forwarded.
- An ack that arrives while rem = 0 is ignored and does not underflow rem.
- If the granted master raises stb while rem = 0 and in the same cycle drops cyc, go to IDLE. The request is not issued.
- Reset asserted mid-burst: the block returns to IDLE immediately. The downstream side must be reset together with it.

## Timing
- Reset values: state = IDLE, gnt = 0, last = 1, rem = 0. Every output is 0.
- The grant decision is registered. A request seen in IDLE at edge N drives s_wb_cyc and s_wb_stb during cycle N+1.
- Acks pass through combinationally: mx_wb_ack is valid in the same cycle as s_wb_ack. s_wb_i_dat passes through unregistered.
- Releasing the grant always goes through at least one IDLE cycle, so there is a one-cycle bubble when switching masters.
- s_wb_stb drops in the cycle after the last ack is consumed, unless the grant is reloaded.

## Configuration
ARB_ROUND_ROBIN_EN:
- Defined: when both masters request in IDLE, the winner is ~last. A lone requester always wins.
- Undefined: fixed priority, m0 always wins. The last register is still present but has no effect on arbitration.

## Test plan
- Single m1 read, no burst, ack returned 2 cycles after stb → s_wb_cyc rises 1 cycle after the request; m1_wb_ack fires once; m0_wb_ack stays 0; state is back in IDLE 1 cycle after m1 drops cyc.
- m0 read with 8_burst=1, m1 requesting throughout → m1 gets no grant until the 8th ack; rem counts 8 down to 0; m1 is granted 2 cycles after m0 drops cyc.
- Both masters request continuously with 1-beat reads, ARB_ROUND_ROBIN_EN defined → grants alternate 0, 1, 0, 1 (first grant to m0). With the macro undefined → m0 is granted every time.
- m0 4_burst read that drops cyc after the 1st ack → state enters DRAIN; s_wb_stb = 0; the remaining 3 acks are not forwarded; then IDLE.
- m1 write with 8_burst=1 → rem loads 1; grant is released after a single ack.
- i_rst_n pulsed low while rem = 5 → all outputs are 0 asynchronously; after release, state = IDLE and rem = 0.
